// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the femtoRV32 fetch stage: FSM encoding, bubble word, IF/ID field layout.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  localparam int IFID_PC_MSB    = 63;
  localparam int IFID_PC_LSB    = 32;
  localparam int IFID_INSTR_MSB = 31;
  localparam int IFID_INSTR_LSB = 0;

  function automatic logic [63:0] pack_ifid(input logic [31:0] pc, input logic [31:0] instr);
    logic [63:0] w;
    w = '0;
    w[IFID_PC_MSB:IFID_PC_LSB]       = pc;
    w[IFID_INSTR_MSB:IFID_INSTR_LSB] = instr;
    return w;
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating 32-bit event counters for the fetch stage.
// One-edge update latency; counters stick at all-ones instead of wrapping.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        wait_cycle,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes,
  output logic [31:0] perf_wait_cycles
);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
      perf_wait_cycles  <= '0;
    end else begin
      if (stall && perf_stall_cycles != 32'hFFFF_FFFF)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush && perf_flushes != 32'hFFFF_FFFF)
        perf_flushes <= perf_flushes + 32'd1;
      if (wait_cycle && perf_wait_cycles != 32'hFFFF_FFFF)
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register; zero-wait memory gives one instr/cycle, N waits insert N bubbles.
// Stall parks an early word in HOLD; flush redirects and drops any stale ack. Optional FETCH_PERF_EN counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc_out,
  output logic [63:0] if_id_out,
  output logic        if_id_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes,
  output logic [31:0] perf_wait_cycles
`endif
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  stale_addr;
  logic [63:0]  ifid;
  logic [63:0]  hold;
  logic         valid;
  logic [31:0]  target;

  assign target = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (flush)                 state_nxt = imem_ack ? FETCH : DISCARD;
        else if (imem_ack && stall) state_nxt = HOLD;
      end
      HOLD:    if (flush || !stall) state_nxt = FETCH;
      // A flush here keeps waiting for the original stale ack.
      DISCARD: if (imem_ack)        state_nxt = FETCH;
      default:                      state_nxt = FETCH;
    endcase
  end

  always_comb begin
    imem_req  = !rst && (state != HOLD);
    imem_addr = (state == DISCARD) ? stale_addr : pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      stale_addr <= RESET_PC;
      ifid       <= pack_ifid(RESET_PC, NOP_INSTR);
      hold       <= '0;
      valid      <= 1'b0;
    end else if (flush) begin
      pc    <= target;
      ifid  <= pack_ifid(target, NOP_INSTR);
      valid <= 1'b0;
      if (state == FETCH && !imem_ack) stale_addr <= pc;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            if (stall) begin
              hold <= pack_ifid(pc, imem_rdata);
            end else begin
              ifid  <= pack_ifid(pc, imem_rdata);
              valid <= 1'b1;
              pc    <= pc + 32'd4;
            end
          end else if (!stall) begin
            ifid  <= pack_ifid(pc, NOP_INSTR);
            valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid  <= hold;
            valid <= 1'b1;
            pc    <= pc + 32'd4;
          end
        end
        DISCARD: begin
          if (!stall) begin
            ifid  <= pack_ifid(pc, NOP_INSTR);
            valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_out      = pc;
  assign if_id_out   = ifid;
  assign if_id_valid = valid;

`ifdef FETCH_PERF_EN
  logic wait_cycle;
  assign wait_cycle = (state == FETCH || state == DISCARD) && !imem_ack;

  fetch_perf_counters u_perf (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .wait_cycle        (wait_cycle),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes),
    .perf_wait_cycles  (perf_wait_cycles)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns addr+1, ack gated by ack_en.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc_out;
  logic [63:0] if_id_out;
  logic        if_id_valid;
  logic        ack_en;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;
  logic [31:0] perf_wait_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    imem_rdata = imem_addr + 32'd1;
    imem_ack   = ack_en & imem_req;
  end

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .pc_out      (pc_out),
    .if_id_out   (if_id_out),
    .if_id_valid (if_id_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes),
    .perf_wait_cycles  (perf_wait_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0; ack_en = 1'b0;
    step; step;
    chk("rst_pc",    64'(pc_out), 64'h0);
    chk("rst_addr",  64'(imem_addr), 64'h0);
    chk("rst_ifid",  if_id_out, 64'h0000_0000_0000_0013);
    chk("rst_valid", 64'(if_id_valid), 64'd0);
    chk("rst_req",   64'(imem_req), 64'd0);

    rst = 1'b0; ack_en = 1'b1;
    #1 chk("req_after_rst", 64'(imem_req), 64'd1);
    step;
    chk("zw0_ifid",  if_id_out, 64'h0000_0000_0000_0001);
    chk("zw0_valid", 64'(if_id_valid), 64'd1);
    step;
    chk("zw4_ifid",  if_id_out, 64'h0000_0004_0000_0005);
    step;
    chk("zw8_ifid",  if_id_out, 64'h0000_0008_0000_0009);
    chk("zw8_pc",    64'(pc_out), 64'hC);

    // two wait cycles at pc=0xC
    ack_en = 1'b0;
    step;
    chk("wait1_ifid",  if_id_out, 64'h0000_000C_0000_0013);
    chk("wait1_valid", 64'(if_id_valid), 64'd0);
    chk("wait1_pc",    64'(pc_out), 64'hC);
    step;
    chk("wait2_ifid",  if_id_out, 64'h0000_000C_0000_0013);
    chk("wait2_pc",    64'(pc_out), 64'hC);
    ack_en = 1'b1;
    step;
    chk("wait_done_ifid",  if_id_out, 64'h0000_000C_0000_000D);
    chk("wait_done_valid", 64'(if_id_valid), 64'd1);

    // load-use stall with same-cycle ack at pc=0x10
    stall = 1'b1;
    step;
    chk("hold_ifid", if_id_out, 64'h0000_000C_0000_000D);
    chk("hold_pc",   64'(pc_out), 64'h10);
    chk("hold_req",  64'(imem_req), 64'd0);
    stall = 1'b0; ack_en = 1'b0;
    step;
    chk("release_ifid",  if_id_out, 64'h0000_0010_0000_0011);
    chk("release_valid", 64'(if_id_valid), 64'd1);
    chk("release_pc",    64'(pc_out), 64'h14);

    // flush while request for 0x14 is outstanding
    step;
    chk("pre_flush_ifid", if_id_out, 64'h0000_0014_0000_0013);
    flush = 1'b1; redirect_pc = 32'h0000_0103;
    step;
    flush = 1'b0;
    chk("disc_addr",  64'(imem_addr), 64'h14);
    chk("disc_req",   64'(imem_req), 64'd1);
    chk("disc_pc",    64'(pc_out), 64'h100);
    chk("disc_ifid",  if_id_out, 64'h0000_0100_0000_0013);
    chk("disc_valid", 64'(if_id_valid), 64'd0);
    step;
    chk("disc_addr2", 64'(imem_addr), 64'h14);
    ack_en = 1'b1;
    step;
    chk("drop_ifid",  if_id_out, 64'h0000_0100_0000_0013);
    chk("drop_valid", 64'(if_id_valid), 64'd0);
    chk("drop_addr",  64'(imem_addr), 64'h100);
    step;
    chk("target_ifid",  if_id_out, 64'h0000_0100_0000_0101);
    chk("target_valid", 64'(if_id_valid), 64'd1);

    // flush and stall together while in HOLD
    stall = 1'b1;
    step;
    chk("hold2_req",  64'(imem_req), 64'd0);
    chk("hold2_ifid", if_id_out, 64'h0000_0100_0000_0101);
    flush = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step;
    flush = 1'b0; stall = 1'b0;
    chk("hflush_ifid",  if_id_out, 64'hFFFF_FFF8_0000_0013);
    chk("hflush_valid", 64'(if_id_valid), 64'd0);
    chk("hflush_pc",    64'(pc_out), 64'hFFFF_FFF8);
    chk("hflush_req",   64'(imem_req), 64'd1);
    step;
    chk("wrapm8_ifid", if_id_out, 64'hFFFF_FFF8_FFFF_FFF9);
    step;
    chk("wrapm4_ifid", if_id_out, 64'hFFFF_FFFC_FFFF_FFFD);
    chk("wrap_pc",     64'(pc_out), 64'h0);

    // flush with same-cycle ack stays in FETCH, then wait and reset mid-request
    flush = 1'b1; redirect_pc = 32'h0000_0040;
    step;
    flush = 1'b0;
    chk("fack_pc",   64'(pc_out), 64'h40);
    chk("fack_addr", 64'(imem_addr), 64'h40);
    chk("fack_ifid", if_id_out, 64'h0000_0040_0000_0013);
    ack_en = 1'b0;
    step;
    chk("w40_pc", 64'(pc_out), 64'h40);
`ifdef FETCH_PERF_EN
    chk("perf_stall", 64'(perf_stall_cycles), 64'd3);
    chk("perf_flush", 64'(perf_flushes), 64'd3);
    chk("perf_wait",  64'(perf_wait_cycles), 64'd6);
`endif
    rst = 1'b1;
    #1 chk("mid_rst_req", 64'(imem_req), 64'd0);
    step;
    chk("mid_rst_pc",    64'(pc_out), 64'h0);
    chk("mid_rst_valid", 64'(if_id_valid), 64'd0);
    chk("mid_rst_ifid",  if_id_out, 64'h0000_0000_0000_0013);
`ifdef FETCH_PERF_EN
    chk("perf_rst_wait", 64'(perf_wait_cycles), 64'd0);
`endif
    rst = 1'b0; ack_en = 1'b1;
    step;
    chk("post_rst_ifid", if_id_out, 64'h0000_0000_0000_0001);
    chk("post_rst_pc",   64'(pc_out), 64'h4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
